// File: rtl/nb_pair_streamer.sv
// Non-bonded pair source: buffers an atom set, walks every i<j pair, emits q_i/q_j and Q16.16 1/r^2.
// Optional macro NB_CUTOFF_EN: pairs with r2 > CUTOFF2 are skipped without a divide or emit.
module nb_pair_streamer #(
  parameter int          MAX_ATOMS = 8,
  parameter logic [31:0] CUTOFF2   = 32'h00900000,
  localparam int         IW        = $clog2(MAX_ATOMS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_x,
  input  logic [31:0]   in_y,
  input  logic [31:0]   in_z,
  input  logic [31:0]   in_q,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_q_i,
  output logic [31:0]   out_q_j,
  output logic [31:0]   out_r2_inv,
  output logic [IW-1:0] out_i_idx,
  output logic [IW-1:0] out_j_idx,
  output logic          busy,
  output logic          done,
  output logic          err_overflow
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIST, S_DIV, S_EMIT, S_DONE} state_t;

  localparam logic [IW:0] ONE  = (IW+1)'(1);
  localparam logic [IW:0] TWO  = (IW+1)'(2);
  localparam logic [IW:0] NMAX = (IW+1)'(MAX_ATOMS);

  state_t        state_q, state_d;
  logic [IW:0]   n_q, n_d, i_q, i_d, j_q, j_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [31:0]   r2_q, r2_d, rem_q, rem_d, quot_q, quot_d;
  logic [31:0]   qi_q, qi_d, qj_q, qj_d, inv_q, inv_d;
  logic [IW-1:0] ii_q, ii_d, jj_q, jj_d;
  logic          err_q, err_d;
  logic          wr_en, clr_buf;

  logic [31:0] xb [MAX_ATOMS];
  logic [31:0] yb [MAX_ATOMS];
  logic [31:0] zb [MAX_ATOMS];
  logic [31:0] qb [MAX_ATOMS];

  // Q16.16 square: full 64-bit signed product, keep bits [47:16].
  function automatic logic [31:0] sq16(input logic signed [31:0] d);
    logic signed [63:0] p;
    p = d * d;
    return 32'(p >>> 16);
  endfunction

  logic [IW-1:0]      ia, ja;
  logic signed [31:0] dx, dy, dz;
  logic [33:0]        r2_sum;
  logic [31:0]        r2_c;
  logic               skip;

  assign ia     = i_q[IW-1:0];
  assign ja     = j_q[IW-1:0];
  assign dx     = xb[ia] - xb[ja];
  assign dy     = yb[ia] - yb[ja];
  assign dz     = zb[ia] - zb[ja];
  assign r2_sum = {2'b00, sq16(dx)} + {2'b00, sq16(dy)} + {2'b00, sq16(dz)};
  assign r2_c   = (r2_sum[33:32] != 2'b00) ? 32'hFFFFFFFF : r2_sum[31:0];

`ifdef NB_CUTOFF_EN
  assign skip = (r2_c > CUTOFF2);
`else
  // CUTOFF2 has no effect in this build; the term folds to 0.
  assign skip = 1'b0 && (r2_c > CUTOFF2);
`endif

  // Restoring divide of 2^32 by r2: the dividend's single 1 bit enters on the first step.
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_nx, quot_nx;

  assign rem_sh  = {rem_q, (cnt_q == 6'd0)};
  assign ge      = (rem_sh >= {1'b0, r2_q});
  assign rem_nx  = ge ? 32'(rem_sh - {1'b0, r2_q}) : rem_sh[31:0];
  assign quot_nx = 32'({quot_q, ge});

  logic [IW:0] j_inc, i_adv, j_adv;
  logic        wrap, last_pair;

  assign j_inc     = j_q + ONE;
  assign wrap      = (j_inc == n_q);
  assign last_pair = wrap && (i_q + TWO == n_q);
  assign i_adv     = wrap ? i_q + ONE : i_q;
  assign j_adv     = wrap ? i_q + TWO : j_inc;

  always_comb begin
    state_d = state_q; n_d = n_q; i_d = i_q; j_d = j_q; cnt_d = cnt_q;
    r2_d = r2_q; rem_d = rem_q; quot_d = quot_q;
    qi_d = qi_q; qj_d = qj_q; inv_d = inv_q; ii_d = ii_q; jj_d = jj_q;
    err_d = err_q; wr_en = 1'b0; clr_buf = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          n_d     = n_q + ONE;
          state_d = S_LOAD;
          if (in_last || (n_q + ONE == NMAX)) begin
            err_d   = err_q | ~in_last;
            i_d     = '0;
            j_d     = ONE;
            state_d = (n_q + ONE < TWO) ? S_DONE : S_DIST;
          end
        end
      end
      S_DIST: begin
        qi_d = qb[ia]; qj_d = qb[ja]; ii_d = ia; jj_d = ja;
        r2_d = r2_c; rem_d = '0; quot_d = '0; cnt_d = '0;
        if (skip) begin
          i_d = i_adv; j_d = j_adv;
          state_d = last_pair ? S_DONE : S_DIST;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d  = rem_nx;
        quot_d = quot_nx;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd32) begin
          inv_d   = (r2_q <= 32'd2) ? 32'h7FFFFFFF : quot_nx;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          i_d = i_adv; j_d = j_adv;
          state_d = last_pair ? S_DONE : S_DIST;
        end
      end
      S_DONE: begin
        n_d     = '0;
        clr_buf = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE; n_q <= '0; i_q <= '0; j_q <= '0; cnt_q <= '0;
      r2_q <= '0; rem_q <= '0; quot_q <= '0;
      qi_q <= '0; qj_q <= '0; inv_q <= '0; ii_q <= '0; jj_q <= '0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; n_q <= n_d; i_q <= i_d; j_q <= j_d; cnt_q <= cnt_d;
      r2_q <= r2_d; rem_q <= rem_d; quot_q <= quot_d;
      qi_q <= qi_d; qj_q <= qj_d; inv_q <= inv_d; ii_q <= ii_d; jj_q <= jj_d; err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_buf) begin
      for (int k = 0; k < MAX_ATOMS; k++) begin
        xb[k] <= '0; yb[k] <= '0; zb[k] <= '0; qb[k] <= '0;
      end
    end else if (wr_en) begin
      xb[n_q[IW-1:0]] <= in_x;
      yb[n_q[IW-1:0]] <= in_y;
      zb[n_q[IW-1:0]] <= in_z;
      qb[n_q[IW-1:0]] <= in_q;
    end
  end

  assign in_ready     = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign out_valid    = (state_q == S_EMIT);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err_overflow = err_q;
  assign out_q_i      = qi_q;
  assign out_q_j      = qj_q;
  assign out_r2_inv   = inv_q;
  assign out_i_idx    = ii_q;
  assign out_j_idx    = jj_q;
endmodule

// File: tb/tb_nb_pair_streamer.sv
// Directed bench for nb_pair_streamer (MAX_ATOMS=4); expectations are hand-computed Q16.16 values.
module tb_nb_pair_streamer;
  localparam int          MAXA  = 4;
  localparam int          IW    = 2;
  localparam logic [31:0] ONE_Q = 32'h00010000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [31:0]   in_x = '0, in_y = '0, in_z = '0, in_q = '0;
  logic          in_ready, out_valid, busy, done, err_overflow;
  logic [31:0]   out_q_i, out_q_j, out_r2_inv;
  logic [IW-1:0] out_i_idx, out_j_idx;

  int          tests = 0, fails = 0, cyc = 0;
  int          exp_i [6];
  int          exp_j [6];
  logic [31:0] exp_inv [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nb_pair_streamer #(.MAX_ATOMS(MAXA), .CUTOFF2(32'h00040000)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_q(in_q), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q_i(out_q_i), .out_q_j(out_q_j), .out_r2_inv(out_r2_inv),
    .out_i_idx(out_i_idx), .out_j_idx(out_j_idx),
    .busy(busy), .done(done), .err_overflow(err_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                      input logic [31:0] q, input logic last);
    int w;
    w = 0;
    in_x = x; in_y = y; in_z = z; in_q = q; in_last = last; in_valid = 1'b1;
    while (!in_ready && w < 50) begin tick(); w++; end
    chk("push_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int k);
    k = 0;
    while (!out_valid && k < 200) begin tick(); k++; end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic set_pair(input int p, input int i, input int j, input logic [31:0] inv);
    exp_i[p] = i; exp_j[p] = j; exp_inv[p] = inv;
  endtask

  // Atoms in multi-atom sets carry charge (index+1).0, so q_i/q_j follow from the indices.
  task automatic collect(input string tag, input int np, input int gap);
    int k, last_cyc;
    last_cyc = 0;
    for (int p = 0; p < np; p++) begin
      wait_valid({tag, "_vld"}, k);
      if (p > 0 && gap > 0) chk({tag, "_gap"}, 32'(cyc - last_cyc), 32'(gap));
      last_cyc = cyc;
      chk({tag, "_i"},   32'(out_i_idx), 32'(exp_i[p]));
      chk({tag, "_j"},   32'(out_j_idx), 32'(exp_j[p]));
      chk({tag, "_qi"},  out_q_i, 32'((exp_i[p] + 1) << 16));
      chk({tag, "_qj"},  out_q_j, 32'((exp_j[p] + 1) << 16));
      chk({tag, "_inv"}, out_r2_inv, exp_inv[p]);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    in_valid = 1'b0;
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, xfers;
    tick(); tick();
    chk("rst_vld",   32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err_overflow), 32'd0);
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_qi",    out_q_i, 32'd0);
    chk("rst_inv",   out_r2_inv, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single pair, dx = -2.0 -> r2 = 4.0 -> 1/r2 = 0.25.
    push(32'h0, 32'h0, 32'h0, ONE_Q, 1'b0);
    push(32'h00020000, 32'h0, 32'h0, 32'hFFFF0000, 1'b1);
    chk("t1_busy",  32'(busy), 32'd1);
    chk("t1_inrdy", 32'(in_ready), 32'd0);
    wait_valid("t1_vld", k);
    // DIST is cycle 1, DIV cycles 2..34, EMIT is the 35th cycle.
    chk("t1_lat", 32'(k), 32'd34);
    chk("t1_qi",  out_q_i, 32'h00010000);
    chk("t1_qj",  out_q_j, 32'hFFFF0000);
    chk("t1_inv", out_r2_inv, 32'h00004000);
    chk("t1_i",   32'(out_i_idx), 32'd0);
    chk("t1_j",   32'(out_j_idx), 32'd1);
    tick();
    chk("t1_done",    32'(done), 32'd1);
    chk("t1_vld_off", 32'(out_valid), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_inrdy_idle", 32'(in_ready), 32'd1);

    // Three atoms on x at 0, 1.0, 2.0.
    for (int a = 0; a < 3; a++) push(32'(a) << 16, 32'h0, 32'h0, 32'(a + 1) << 16, a == 2);
    set_pair(0, 0, 1, 32'h00010000);
    set_pair(1, 0, 2, 32'h00004000);
    set_pair(2, 1, 2, 32'h00010000);
    collect("t2", 3, 35);

    // Mixed-sign 3D offset: r2 = 0.25 + 0.25 + 1.0 = 1.5 -> 65536/1.5.
    push(32'h00004000, 32'hFFFF8000, 32'h0, 32'h00010000, 1'b0);
    push(32'hFFFFC000, 32'h0, 32'h00010000, 32'h00020000, 1'b1);
    set_pair(0, 0, 1, 32'h0000AAAA);
    collect("t3", 1, 0);

    // Small-r2 boundary: raw r2 of 2, 3 and 0.
    push(32'h0, 32'h0, 32'h0, 32'h00010000, 1'b0);
    push(32'h00000180, 32'h0, 32'h0, 32'h00020000, 1'b0);
    push(32'h000001C0, 32'h0, 32'h0, 32'h00030000, 1'b1);
    set_pair(0, 0, 1, 32'h7FFFFFFF);
    set_pair(1, 0, 2, 32'h55555555);
    set_pair(2, 1, 2, 32'h7FFFFFFF);
    collect("t4", 3, 35);

    // Coincident atoms under back-pressure.
    out_ready = 1'b0;
    push(ONE_Q, ONE_Q, ONE_Q, 32'h00010000, 1'b0);
    push(ONE_Q, ONE_Q, ONE_Q, 32'h00020000, 1'b1);
    wait_valid("t5_vld", k);
    for (int c = 0; c < 10; c++) begin
      chk("t5_hold_vld", 32'(out_valid), 32'd1);
      chk("t5_hold_qj",  out_q_j, 32'h00020000);
      chk("t5_hold_inv", out_r2_inv, 32'h7FFFFFFF);
      chk("t5_hold_j",   32'(out_j_idx), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    xfers = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid && out_ready) xfers++;
      tick();
    end
    chk("t5_xfers", 32'(xfers), 32'd1);
    chk("t5_idle",  32'(busy), 32'd0);

    // x at 0, 1.0, 3.0: r2 = 1, 9, 4.
    for (int a = 0; a < 3; a++) push((a == 2) ? 32'h00030000 : 32'(a) << 16, 32'h0, 32'h0,
                                     32'(a + 1) << 16, a == 2);
`ifdef NB_CUTOFF_EN
    // Cutoff 4.0: (0,2) exceeds it and is skipped; (1,2) sits exactly on it and is kept.
    set_pair(0, 0, 1, 32'h00010000);
    set_pair(1, 1, 2, 32'h00004000);
    collect("t6", 2, 0);
`else
    set_pair(0, 0, 1, 32'h00010000);
    set_pair(1, 0, 2, 32'h00001C71);
    set_pair(2, 1, 2, 32'h00004000);
    collect("t6", 3, 35);
`endif

    // Overflow: four atoms at 0.5 spacing without in_last, a fifth held on the input.
    for (int a = 0; a < 4; a++) push(32'(a) << 15, 32'h0, 32'h0, 32'(a + 1) << 16, 1'b0);
    chk("t7_err",   32'(err_overflow), 32'd1);
    chk("t7_inrdy", 32'(in_ready), 32'd0);
    in_x = 32'h00020000; in_q = 32'h00050000; in_last = 1'b0; in_valid = 1'b1;
    tick();
    chk("t7_inrdy_hold", 32'(in_ready), 32'd0);
    set_pair(0, 0, 1, 32'h00040000);
    set_pair(1, 0, 2, 32'h00010000);
    set_pair(2, 0, 3, 32'h000071C7);
    set_pair(3, 1, 2, 32'h00040000);
    set_pair(4, 1, 3, 32'h00010000);
    set_pair(5, 2, 3, 32'h00040000);
    collect("t7", 6, 35);
    chk("t7_err_sticky", 32'(err_overflow), 32'd1);
    chk("t7_inrdy_idle", 32'(in_ready), 32'd1);

    // Synchronous reset while a pair is in DIV, then a clean rerun.
    push(32'h0, 32'h0, 32'h0, 32'h00010000, 1'b0);
    push(32'h00020000, 32'h0, 32'h0, 32'h00020000, 1'b1);
    repeat (10) tick();
    chk("t8_div_vld",  32'(out_valid), 32'd0);
    chk("t8_div_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t8_rst_busy",  32'(busy), 32'd0);
    chk("t8_rst_vld",   32'(out_valid), 32'd0);
    chk("t8_rst_inrdy", 32'(in_ready), 32'd1);
    chk("t8_rst_err",   32'(err_overflow), 32'd0);
    rst_n = 1'b1;
    tick();
    push(32'h0, 32'h0, 32'h0, 32'h00010000, 1'b0);
    push(32'h00020000, 32'h0, 32'h0, 32'h00020000, 1'b1);
    set_pair(0, 0, 1, 32'h00004000);
    collect("t8", 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
